mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM between the instruction-fetch port and the LSU data port.
//  Serves one transaction at a time through a 4-state FSM, with req/ack handshakes on both ports.
//  LSU has fixed priority; a starvation guard guarantees fetch progress.
//  Sits between pc_reg/lsu and the unified memory, so the core can move from split to unified memory.
// PARAMETERS
//  ADDR_W      32  byte-address width on all ports
//  DATA_W      32  data width; byte mask is DATA_W/8 bits
//  MEM_LAT     1   SRAM read latency in cycles (>=1); data valid MEM_LAT cycles after the en cycle
//  STARVE_MAX  4   consecutive LS grants allowed while IF waits (>=1)
// PORTS
//  i_clk        in   1         system clock, rising edge
//  i_rst_n      in   1         asynchronous, active-low reset
//  i_if_req     in   1         fetch request; held with i_if_addr until o_if_ack
//  i_if_addr    in   ADDR_W    fetch address
//  o_if_ack     out  1         one-cycle completion pulse for fetch
//  o_if_rdata   out  DATA_W    fetched word, valid while o_if_ack=1, held afterwards
//  i_ls_req     in   1         LSU request; payload held until o_ls_ack
//  i_ls_wren    in   1         1=store, 0=load
//  i_ls_addr    in   ADDR_W    LSU address
//  i_ls_mask    in   DATA_W/8  byte enables for stores
//  i_ls_wdata   in   DATA_W    store data
//  o_ls_ack     out  1         one-cycle completion pulse for LSU
//  o_ls_rdata   out  DATA_W    load word, valid while o_ls_ack=1, held afterwards
//  o_mem_en     out  1         SRAM access strobe, one cycle per transaction
//  o_mem_we     out  1         SRAM write enable, qualified by o_mem_en
//  o_mem_addr   out  ADDR_W    SRAM address (latched)
//  o_mem_bmask  out  DATA_W/8  SRAM byte mask (IF reads: all ones)
//  o_mem_wdata  out  DATA_W    SRAM write data
//  i_mem_rdata  in   DATA_W    SRAM read data
//  o_busy       out  1         1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset
//   - Every output and register goes to 0. FSM goes to IDLE. Starvation counter goes to 0.
//   - An in-flight transaction is dropped: no ack is produced and the requester must re-request.
//  FSM states: IDLE -> ISSUE -> [WAIT x MEM_LAT] -> ACK -> IDLE.
//  IDLE: arbitrate on the requests sampled this cycle.
//   - If i_ls_req=1 and starve_cnt<STARVE_MAX, grant LS.
//   - Otherwise, if i_if_req=1, grant IF.
//   - Otherwise, if i_ls_req=1, grant LS. This covers IF being idle.
//   - On a grant, latch address, mask, wdata and we into the o_mem_* registers and go to ISSUE.
//  ISSUE: o_mem_en=1 for exactly this cycle.
//   - Store: go to ACK.
//   - Load or fetch: go to WAIT.
//  WAIT: stay for MEM_LAT cycles, counted by wait_cnt.
//   - Capture i_mem_rdata into the granted port's rdata register on the last WAIT cycle.
//  ACK: pulse the granted port's ack for 1 cycle, then go to IDLE. No arbitration happens in ACK.
//  Latency, with the request first seen in IDLE at cycle T0:
//   - Store: ack at T0+2.
//   - Load or fetch: ack at T0+MEM_LAT+2.
//   - Back-to-back requests: the next grant is decided at ack+1.
//  Starvation counter
//   - Increment on an LS grant while i_if_req=1, saturating at STARVE_MAX.
//   - Clear on an IF grant, and in any IDLE cycle where i_if_req=0.
//  Simultaneous requests, MEM_LAT=1, STARVE_MAX=4: grant order is LS,LS,LS,LS,IF,LS,...
//  Payload rules
//   - The payload is latched at grant. Changes on the request inputs after grant do not affect the transaction.
//   - A req dropped before its ack is a protocol violation. The transaction still completes and its ack is still pulsed.
//  Output hold rules
//   - o_mem_addr, o_mem_bmask, o_mem_wdata and o_mem_we keep the last latched value.
//   - o_mem_we is meaningful only when o_mem_en=1.
//   - o_if_rdata and o_ls_rdata change only on a capture for their own port.
//  Widths: o_mem_bmask is 4'b1111 for IF grants. Addresses pass through unmodified; no alignment check.
// STRUCTURE
//  Package mem_arb_pkg
//   - typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} arb_state_e.
//   - typedef enum logic {GNT_IF, GNT_LS} arb_gnt_e.
//  Sub-module mem_arb_starve_cnt
//   - Saturating counter with inc, clr and a sat flag.
//   - Parameter STARVE_MAX; reset on i_rst_n.
//  Everything else (FSM, wait_cnt, payload and rdata registers) lives in mem_arbiter.
// TESTING
//  1. Reset mid-WAIT. IF read in flight, pulse i_rst_n=0 -> all outputs 0 at once, no o_if_ack, o_busy=0.
//  2. IF read, MEM_LAT=2.
//     Stimulus: i_if_req at T0, addr 0x0000_0010, mem returns 0x0051_3093.
//     Response: o_mem_en at T0+1, o_if_ack at T0+4, o_if_rdata=0x0051_3093.
//  3. LS store, MEM_LAT=1.
//     Stimulus: addr 0x0000_2004, mask 4'b0011, wdata 0xDEAD_BEEF.
//     Response: o_mem_en=o_mem_we=1 at T0+1 with the same addr/mask/data; o_ls_ack at T0+2.
//  4. Both requesters held continuously, STARVE_MAX=4 -> grants LS,LS,LS,LS,IF,LS; no IF wait exceeds 4 LS grants.
//  5. Payload change after grant. Change i_ls_addr 0x100->0x200 during WAIT -> o_mem_addr stays 0x100, load ack'd normally.
//  6. Back-to-back loads. LS issues a new load at ack+1 -> grant at ack+1, o_mem_en at ack+2, no dead cycles beyond the FSM.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and helpers for the unified-memory arbiter.
//   - arb_state_e : transaction FSM states (IDLE -> ISSUE -> WAIT* -> ACK)
//   - arb_gnt_e   : which requester owns the transaction in flight
//   - cnt_width   : bit width needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } arb_gnt_e;

    // Width of a counter that must represent 0..max_val inclusive (never less than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_cnt
//   Saturating counter of consecutive LSU grants taken while fetch was waiting.
//   Once it reaches STARVE_MAX the arbiter lets fetch through ahead of the LSU.
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset, counter to 0
//   i_inc    : count one more LSU grant (ignored once saturated)
//   i_clr    : clear the counter (wins over i_inc)
//   o_sat    : counter has reached STARVE_MAX
// -----------------------------------------------------------------------------
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int unsigned CntW = cnt_width(STARVE_MAX);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_sat = (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous SRAM between instruction fetch (IF) and
//   the LSU (LS). One transaction at a time; LS has fixed priority, but after
//   STARVE_MAX consecutive LS grants with IF waiting, IF is served next.
//
// Ports
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_if_req / i_if_addr           : fetch request, held until o_if_ack
//   o_if_ack / o_if_rdata          : fetch completion pulse, fetched word (held)
//   i_ls_req / i_ls_wren           : LSU request, 1 = store, 0 = load
//   i_ls_addr/i_ls_mask/i_ls_wdata : LSU payload, held until o_ls_ack
//   o_ls_ack / o_ls_rdata          : LSU completion pulse, load word (held)
//   o_mem_en / o_mem_we            : SRAM strobe (one cycle) and write enable
//   o_mem_addr/o_mem_bmask/o_mem_wdata : latched SRAM payload
//   i_mem_rdata                    : SRAM read data, valid MEM_LAT cycles after o_mem_en
//   o_busy                         : FSM is not idle
//
// Timing with a request first seen in IDLE at T0:
//   store      : o_mem_en at T0+1, ack at T0+2
//   load/fetch : o_mem_en at T0+1, ack at T0+MEM_LAT+2
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_ack,
    output logic [DATA_W-1:0]     o_if_rdata,

    input  logic                  i_ls_req,
    input  logic                  i_ls_wren,
    input  logic [ADDR_W-1:0]     i_ls_addr,
    input  logic [DATA_W/8-1:0]   i_ls_mask,
    input  logic [DATA_W-1:0]     i_ls_wdata,
    output logic                  o_ls_ack,
    output logic [DATA_W-1:0]     o_ls_rdata,

    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W/8-1:0]   o_mem_bmask,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata,

    output logic                  o_busy
);

    localparam int unsigned MaskW = DATA_W / 8;
    localparam int unsigned WaitW = cnt_width(MEM_LAT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_LAT - 1);

    arb_state_e          state_q,     state_d;
    arb_gnt_e            gnt_q,       gnt_d;
    logic [WaitW-1:0]    wait_cnt_q,  wait_cnt_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [MaskW-1:0]    mem_bmask_q, mem_bmask_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q,  ls_rdata_d;

    logic grant_ls;
    logic grant_if;
    logic starve_inc;
    logic starve_clr;
    logic starve_sat;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (starve_inc),
        .i_clr   (starve_clr),
        .o_sat   (starve_sat)
    );

    // Arbitration only happens in IDLE; the grant decision is combinational on
    // the requests present in that cycle.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_ls_req && !starve_sat) begin
                grant_ls = 1'b1;
            end else if (i_if_req) begin
                grant_if = 1'b1;
            end else if (i_ls_req) begin
                // IF is not asking, so the starvation guard does not apply.
                grant_ls = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_bmask_d = mem_bmask_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_if_req) begin
                    starve_clr = 1'b1;
                end
                if (grant_ls) begin
                    gnt_d       = GNT_LS;
                    mem_addr_d  = i_ls_addr;
                    mem_bmask_d = i_ls_mask;
                    mem_wdata_d = i_ls_wdata;
                    mem_we_d    = i_ls_wren;
                    state_d     = ST_ISSUE;
                    starve_inc  = i_if_req;
                end else if (grant_if) begin
                    // Fetch is always a full-word read; wdata is irrelevant and left as is.
                    gnt_d       = GNT_IF;
                    mem_addr_d  = i_if_addr;
                    mem_bmask_d = '1;
                    mem_we_d    = 1'b0;
                    state_d     = ST_ISSUE;
                    starve_clr  = 1'b1;
                end
            end

            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = mem_we_q ? ST_ACK : ST_WAIT;
            end

            ST_WAIT: begin
                if (wait_cnt_q == WaitLast) begin
                    wait_cnt_d = '0;
                    state_d    = ST_ACK;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = i_mem_rdata;
                    end else begin
                        ls_rdata_d = i_mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            wait_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_bmask_q <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_bmask_q <= mem_bmask_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    // Strobes decode straight from the state register, so reset clears them at once.
    assign o_mem_en    = (state_q == ST_ISSUE);
    assign o_if_ack    = (state_q == ST_ACK) && (gnt_q == GNT_IF);
    assign o_ls_ack    = (state_q == ST_ACK) && (gnt_q == GNT_LS);
    assign o_busy      = (state_q != ST_IDLE);

    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_bmask = mem_bmask_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed plus randomized bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
//   A behavioural SRAM answers the DUT; a separate word-array reference model
//   tracks what every load/fetch must return and the expected grant order.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          WORDS      = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_wren;
    logic [31:0] ls_addr;
    logic [3:0]  ls_mask;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_bmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_vec;
    int n_err;

    logic [31:0] ram     [WORDS];
    logic [31:0] ref_ram [WORDS];
    logic [31:0] pipe    [MEM_LAT];
    logic [31:0] sram_rd;
    logic [31:0] sram_w;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_ls_rd;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_ack    (if_ack),
        .o_if_rdata  (if_rdata),
        .i_ls_req    (ls_req),
        .i_ls_wren   (ls_wren),
        .i_ls_addr   (ls_addr),
        .i_ls_mask   (ls_mask),
        .i_ls_wdata  (ls_wdata),
        .o_ls_ack    (ls_ack),
        .o_ls_rdata  (ls_rdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_bmask (mem_bmask),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy)
    );

    // Behavioural SRAM: read data appears MEM_LAT cycles after the en cycle;
    // every other cycle carries noise so mistimed captures show up.
    always @(posedge clk) begin
        sram_rd = ram[mem_addr[11:2]];
        if (mem_en && mem_we) begin
            sram_w = sram_rd;
            for (int b = 0; b < 4; b++) begin
                if (mem_bmask[b]) sram_w[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
            ram[mem_addr[11:2]] = sram_w;
        end
        pipe[0] <= (mem_en && !mem_we) ? sram_rd : $urandom;
        for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[MEM_LAT-1];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch on an otherwise idle arbiter.
    task automatic run_if(input logic [31:0] addr);
        int   cyc;
        logic extra_en;
        if_req  = 1'b1;
        if_addr = addr;
        tick();
        cyc = 1;
        chkb("if_en", mem_en, 1'b1);
        chkb("if_we", mem_we, 1'b0);
        chk("if_addr", mem_addr, addr);
        chk("if_bmask", 32'(mem_bmask), 32'h0000_000f);
        extra_en = 1'b0;
        while (!if_ack && cyc < 20) begin
            tick();
            cyc++;
            if (mem_en) extra_en = 1'b1;
        end
        chk("if_lat", cyc, MEM_LAT + 2);
        chkb("if_en_once", extra_en, 1'b0);
        exp_if_rd = ref_ram[addr[11:2]];
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("ls_rdata_hold", ls_rdata, exp_ls_rd);
        if_req = 1'b0;
        tick();
        chkb("if_idle", busy, 1'b0);
        chkb("if_ack_pulse", if_ack, 1'b0);
        chk("if_rdata_held", if_rdata, exp_if_rd);
    endtask

    // One LSU load or store on an otherwise idle arbiter.
    task automatic run_ls(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wd);
        int   cyc;
        logic extra_en;
        ls_req   = 1'b1;
        ls_wren  = we;
        ls_addr  = addr;
        ls_mask  = mask;
        ls_wdata = wd;
        tick();
        cyc = 1;
        chkb("ls_en", mem_en, 1'b1);
        chkb("ls_we", mem_we, we);
        chk("ls_addr", mem_addr, addr);
        chk("ls_bmask", 32'(mem_bmask), 32'(mask));
        if (we) chk("ls_wdata", mem_wdata, wd);
        extra_en = 1'b0;
        while (!ls_ack && cyc < 20) begin
            tick();
            cyc++;
            if (mem_en) extra_en = 1'b1;
        end
        chk("ls_lat", cyc, we ? 2 : MEM_LAT + 2);
        chkb("ls_en_once", extra_en, 1'b0);
        chkb("ls_no_if_ack", if_ack, 1'b0);
        if (we) ref_ram[addr[11:2]] = merge(ref_ram[addr[11:2]], wd, mask);
        else exp_ls_rd = ref_ram[addr[11:2]];
        chk("ls_rdata", ls_rdata, exp_ls_rd);
        chk("if_rdata_hold", if_rdata, exp_if_rd);
        ls_req = 1'b0;
        tick();
        chkb("ls_idle", busy, 1'b0);
        chkb("ls_ack_pulse", ls_ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          got;
        int          last;
        int          acks;
        int          busy_seen;
        int          ls_run;
        logic        exp_port [6];
        logic        got_port [6];
        logic [31:0] ra;

        n_vec    = 0;
        n_err    = 0;
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_wren  = 1'b0;
        ls_addr  = '0;
        ls_mask  = '0;
        ls_wdata = '0;
        for (int i = 0; i < WORDS; i++) begin
            ram[i]     = $urandom;
            ref_ram[i] = ram[i];
        end
        ram[4]     = 32'h0051_3093;
        ref_ram[4] = 32'h0051_3093;
        exp_if_rd  = '0;
        exp_ls_rd  = '0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_en", mem_en, 1'b0);
        chkb("rst_we", mem_we, 1'b0);
        chkb("rst_if_ack", if_ack, 1'b0);
        chkb("rst_ls_ack", ls_ack, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_bmask", 32'(mem_bmask), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // Fetch from 0x10 returns the preloaded instruction word.
        run_if(32'h0000_0010);
        chk("t2_rdata", if_rdata, 32'h0051_3093);

        // Reset while a fetch sits in WAIT: everything drops, no ack follows.
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        tick();
        tick();
        chkb("t1_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("t1_busy", busy, 1'b0);
        chkb("t1_en", mem_en, 1'b0);
        chkb("t1_if_ack", if_ack, 1'b0);
        chk("t1_if_rdata", if_rdata, 32'h0);
        chk("t1_addr", mem_addr, 32'h0);
        if_req = 1'b0;
        #2 rst_n = 1'b1;
        exp_if_rd = '0;
        acks      = 0;
        busy_seen = 0;
        repeat (8) begin
            tick();
            if (if_ack) acks++;
            if (busy) busy_seen++;
        end
        chk("t1_no_ack", acks, 0);
        chk("t1_stay_idle", busy_seen, 0);

        // Partial store, then read it back through the reference merge.
        run_ls(1'b1, 32'h0000_2004, 4'b0011, 32'hDEAD_BEEF);
        run_ls(1'b0, 32'h0000_2004, 4'b1111, 32'h0);

        // Address change after grant must not reach the SRAM.
        ls_req   = 1'b1;
        ls_wren  = 1'b0;
        ls_addr  = 32'h0000_0100;
        ls_mask  = 4'hf;
        tick();
        chk("t5_addr_issue", mem_addr, 32'h0000_0100);
        ls_addr = 32'h0000_0200;
        tick();
        chk("t5_addr_wait", mem_addr, 32'h0000_0100);
        cyc = 2;
        while (!ls_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t5_lat", cyc, MEM_LAT + 2);
        exp_ls_rd = ref_ram[10'h040];
        chk("t5_rdata", ls_rdata, exp_ls_rd);
        ls_req = 1'b0;
        tick();

        // Both requesters held: expected order from the starvation rule.
        ls_run = 0;
        for (int g = 0; g < 6; g++) begin
            if (ls_run < STARVE_MAX) begin
                exp_port[g] = 1'b1;
                ls_run++;
            end else begin
                exp_port[g] = 1'b0;
                ls_run = 0;
            end
            got_port[g] = 1'bx;
        end
        if_req  = 1'b1;
        if_addr = 32'h0000_0008;
        ls_req  = 1'b1;
        ls_wren = 1'b0;
        ls_addr = 32'h0000_000C;
        ls_mask = 4'hf;
        got  = 0;
        cyc  = 0;
        last = 0;
        while (got < 6 && cyc < 200) begin
            tick();
            cyc++;
            if (if_ack || ls_ack) begin
                chkb("t4_single_ack", if_ack && ls_ack, 1'b0);
                got_port[got] = ls_ack;
                if (ls_ack) begin
                    exp_ls_rd = ref_ram[3];
                    chk("t4_ls_rdata", ls_rdata, exp_ls_rd);
                end else begin
                    exp_if_rd = ref_ram[2];
                    chk("t4_if_rdata", if_rdata, exp_if_rd);
                end
                chk("t4_ack_time", cyc - last, (got == 0) ? MEM_LAT + 2 : MEM_LAT + 3);
                last = cyc;
                got++;
                if (got == 6) begin
                    if_req = 1'b0;
                    ls_req = 1'b0;
                end
            end
        end
        chk("t4_grants", got, 6);
        for (int g = 0; g < 6; g++) chkb($sformatf("t4_order%0d", g), got_port[g], exp_port[g]);
        tick();
        chkb("t4_idle", busy, 1'b0);

        // Back-to-back loads: new load presented in the ack cycle.
        ls_req  = 1'b1;
        ls_wren = 1'b0;
        ls_addr = 32'h0000_0300;
        ls_mask = 4'hf;
        cyc = 0;
        while (!ls_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t6_lat", cyc, MEM_LAT + 2);
        exp_ls_rd = ref_ram[10'h0C0];
        chk("t6_rdata0", ls_rdata, exp_ls_rd);
        ls_addr = 32'h0000_0304;
        tick();
        chkb("t6_grant_idle", busy, 1'b0);
        chkb("t6_no_en", mem_en, 1'b0);
        tick();
        chkb("t6_en", mem_en, 1'b1);
        chk("t6_addr", mem_addr, 32'h0000_0304);
        cyc = 1;
        while (!ls_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t6_lat2", cyc, MEM_LAT + 2);
        exp_ls_rd = ref_ram[10'h0C1];
        chk("t6_rdata1", ls_rdata, exp_ls_rd);
        ls_req = 1'b0;
        tick();

        // Randomized single transactions against the reference word array.
        repeat (40) begin
            ra = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0) begin
                run_if(ra);
            end else begin
                run_ls(1'($urandom_range(0, 1)), ra, 4'($urandom), $urandom);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
